// File: rtl/regfile_scoreboard_pkg.sv
// Shared LemonPC register-file constants and types.
package regfile_scoreboard_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback, issue and flush bundle between the pipeline and the register file.
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned NUM_READ   = 2
);

    logic [NUM_READ*ADDR_WIDTH-1:0] rs_addr;
    logic [NUM_READ*DATA_WIDTH-1:0] rs_data;
    logic [NUM_READ-1:0]            rs_busy;
    logic                           wen;
    logic [ADDR_WIDTH-1:0]          waddr;
    logic [DATA_WIDTH-1:0]          wdata;
    logic                           iss_valid;
    logic [ADDR_WIDTH-1:0]          iss_rd;
    logic                           flush;
    logic [ADDR_WIDTH:0]            pend_cnt;

    modport master (
        output rs_addr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        input  rs_data, rs_busy, pend_cnt
    );

    modport slave (
        input  rs_addr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        output rs_data, rs_busy, pend_cnt
    );

endinterface

// File: rtl/regfile_scoreboard_reg_scoreboard.sv
// Pending-write busy vector with issue/writeback/flush priority and a registered popcount.
module reg_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wen,
    input  logic [ADDR_WIDTH-1:0]   i_waddr,
    input  logic                    i_iss_valid,
    input  logic [ADDR_WIDTH-1:0]   i_iss_rd,
    input  logic                    i_flush,
    output logic [2**ADDR_WIDTH-1:0] o_busy,
    output logic [ADDR_WIDTH:0]     o_pend_cnt
);

    localparam int unsigned Depth = 2**ADDR_WIDTH;
    localparam int unsigned CntW  = ADDR_WIDTH + 1;

    logic [Depth-1:0] r_busy;
    logic [Depth-1:0] w_busy_d;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt;
    logic             w_wr_ok;
    logic             w_iss_ok;

    assign w_wr_ok  = !((ZERO_REG != 0) && (i_waddr == ADDR_WIDTH'(REG_ZERO)));
    assign w_iss_ok = !((ZERO_REG != 0) && (i_iss_rd == ADDR_WIDTH'(REG_ZERO)));

    // Later assignments take priority: issue beats writeback, flush beats both.
    always_comb begin
        w_busy_d = r_busy;
        if (i_wen && w_wr_ok) begin
            w_busy_d[i_waddr] = 1'b0;
        end
        if (i_iss_valid && w_iss_ok) begin
            w_busy_d[i_iss_rd] = 1'b1;
        end
        if (i_flush) begin
            w_busy_d = '0;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            w_cnt = w_cnt + CntW'(w_busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_d;
            r_cnt  <= w_cnt;
        end
    end

    assign o_busy     = r_busy;
    assign o_pend_cnt = r_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// LemonPC integer register file: combinational read ports with write bypass, plus busy scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);

    localparam int unsigned Depth = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [Depth];
    logic [Depth-1:0]      w_busy;
    logic                  w_wr_ok;

    assign w_wr_ok = bus.wen && !((ZERO_REG != 0) && (bus.waddr == ADDR_WIDTH'(REG_ZERO)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[bus.waddr] <= bus.wdata;
        end
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_reg_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_wen       (bus.wen),
        .i_waddr     (bus.waddr),
        .i_iss_valid (bus.iss_valid),
        .i_iss_rd    (bus.iss_rd),
        .i_flush     (bus.flush),
        .o_busy      (w_busy),
        .o_pend_cnt  (bus.pend_cnt)
    );

    for (genvar g = 0; g < int'(NUM_READ); g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_bsy;

        assign w_addr = bus.rs_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

        // Same-cycle issue is deliberately not visible here; decode checks that itself.
        always_comb begin
            w_data = r_mem[w_addr];
            w_bsy  = w_busy[w_addr];
            if ((ZERO_REG != 0) && (w_addr == ADDR_WIDTH'(REG_ZERO))) begin
                w_data = '0;
                w_bsy  = 1'b0;
            end else if ((BYPASS != 0) && bus.wen && (bus.waddr == w_addr)) begin
                w_data = bus.wdata;
                w_bsy  = 1'b0;
            end
        end

        assign bus.rs_data[g*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign bus.rs_busy[g]                          = w_bsy;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two configurations (2 ports/x0 zero/bypass and 3 ports/plain x0/no bypass).
module tb_regfile_scoreboard;

    typedef struct packed {
        logic [2:0][31:0] data;
        logic [2:0]       busy;
        logic [5:0]       cnt;
        logic [1:0]       inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  t_addr [3];
    logic        t_wen, t_iss, t_flush;
    logic [4:0]  t_waddr, t_rd;
    logic [31:0] t_wdata;

    regfile_scoreboard_if #(.NUM_READ(2)) ifa ();
    regfile_scoreboard_if #(.NUM_READ(3)) ifb ();

    assign ifa.rs_addr   = {t_addr[1], t_addr[0]};
    assign ifb.rs_addr   = {t_addr[2], t_addr[1], t_addr[0]};
    assign ifa.wen       = t_wen;
    assign ifb.wen       = t_wen;
    assign ifa.waddr     = t_waddr;
    assign ifb.waddr     = t_waddr;
    assign ifa.wdata     = t_wdata;
    assign ifb.wdata     = t_wdata;
    assign ifa.iss_valid = t_iss;
    assign ifb.iss_valid = t_iss;
    assign ifa.iss_rd    = t_rd;
    assign ifb.iss_rd    = t_rd;
    assign ifa.flush     = t_flush;
    assign ifb.flush     = t_flush;

    regfile_scoreboard u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    regfile_scoreboard #(
        .NUM_READ (3),
        .ZERO_REG (0),
        .BYPASS   (0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Reference model: instance 0 = x0 zero + bypass, instance 1 = ordinary x0, no bypass.
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];
    exp_t        q [$];
    event        mon_ev;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[k][r]  = '0;
                m_busy[k][r] = 1'b0;
            end
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            bit zr = (k == 0);
            if (t_wen && !(zr && t_waddr == 0)) begin
                m_mem[k][t_waddr]  = t_wdata;
                m_busy[k][t_waddr] = 1'b0;
            end
            if (t_iss && !(zr && t_rd == 0)) m_busy[k][t_rd] = 1'b1;
            if (t_flush) begin
                for (int r = 0; r < 32; r++) m_busy[k][r] = 1'b0;
            end
        end
    endtask

    task automatic check_now();
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            int   cnt = 0;
            e      = '0;
            e.inst = 2'(k);
            for (int p = 0; p < 3; p++) begin
                if (k == 0 && t_addr[p] == 0) begin
                    e.data[p] = '0;
                    e.busy[p] = 1'b0;
                end else if (k == 0 && t_wen && t_waddr == t_addr[p]) begin
                    e.data[p] = t_wdata;
                    e.busy[p] = 1'b0;
                end else begin
                    e.data[p] = m_mem[k][t_addr[p]];
                    e.busy[p] = m_busy[k][t_addr[p]];
                end
            end
            for (int r = 0; r < 32; r++) cnt += int'(m_busy[k][r]);
            e.cnt = 6'(cnt);
            q.push_back(e);
        end
        -> mon_ev;
    endtask

    task automatic step(input bit wen, input int wa, input logic [31:0] wd, input bit iss,
                        input int rd, input bit fl, input int a0, input int a1, input int a2);
        @(negedge clk);
        t_wen = wen; t_waddr = 5'(wa); t_wdata = wd;
        t_iss = iss; t_rd = 5'(rd); t_flush = fl;
        t_addr[0] = 5'(a0); t_addr[1] = 5'(a1); t_addr[2] = 5'(a2);
        #1;
        check_now();
        if (!rst) model_clock();
    endtask

    task automatic idle(input int a0, input int a1, input int a2);
        step(1'b0, 0, '0, 1'b0, 0, 1'b0, a0, a1, a2);
    endtask

    // Monitor: pops expected responses whenever the outputs are sampled.
    initial begin
        forever begin
            @(mon_ev);
            while (q.size() > 0) begin
                exp_t        e;
                logic [31:0] ad;
                logic        ab;
                logic [5:0]  ac;
                int          np;
                e  = q.pop_front();
                np = (e.inst == 0) ? 2 : 3;
                ac = (e.inst == 0) ? ifa.pend_cnt : ifb.pend_cnt;
                for (int p = 0; p < np; p++) begin
                    ad = (e.inst == 0) ? ifa.rs_data[p*32 +: 32] : ifb.rs_data[p*32 +: 32];
                    ab = (e.inst == 0) ? ifa.rs_busy[p] : ifb.rs_busy[p];
                    n_checks++;
                    if (ad !== e.data[p]) begin
                        n_errors++;
                        $display("FAIL rs_data inst%0d port%0d @%0t: got %h expected %h",
                                 e.inst, p, $time, ad, e.data[p]);
                    end
                    n_checks++;
                    if (ab !== e.busy[p]) begin
                        n_errors++;
                        $display("FAIL rs_busy inst%0d port%0d @%0t: got %b expected %b",
                                 e.inst, p, $time, ab, e.busy[p]);
                    end
                end
                n_checks++;
                if (ac !== e.cnt) begin
                    n_errors++;
                    $display("FAIL pend_cnt inst%0d @%0t: got %0d expected %0d",
                             e.inst, $time, ac, e.cnt);
                end
            end
        end
    end

    function automatic int rnd_addr();
        return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
    endfunction

    initial begin
        t_wen = 0; t_waddr = 0; t_wdata = 0; t_iss = 0; t_rd = 0; t_flush = 0;
        for (int p = 0; p < 3; p++) t_addr[p] = 5'(p + 5);
        model_reset();
        #3;
        check_now();
        #1;
        rst = 1'b0;

        // Write x5 plus a pending issue, then async reset between edges.
        step(1'b1, 5, 32'h1234, 1'b1, 8, 1'b0, 5, 8, 5);
        idle(5, 8, 5);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_now();
        rst = 1'b0;
        idle(5, 8, 0);

        // x0 write/issue.
        step(1'b1, 0, 32'hDEADBEEF, 1'b1, 0, 1'b0, 0, 0, 0);
        idle(0, 0, 0);

        // Bypass vs array.
        step(1'b1, 3, 32'h11, 1'b0, 0, 1'b0, 3, 3, 3);
        step(1'b1, 3, 32'h22, 1'b0, 0, 1'b0, 1, 3, 3);
        idle(3, 3, 3);

        // Scoreboard set/clear, WAW, same-cycle write+issue.
        step(1'b0, 0, '0, 1'b1, 7, 1'b0, 7, 7, 7);
        idle(7, 7, 7);
        step(1'b0, 0, '0, 1'b1, 7, 1'b0, 7, 7, 7);
        step(1'b1, 7, 32'h5, 1'b0, 0, 1'b0, 7, 9, 7);
        step(1'b1, 9, 32'h99, 1'b1, 9, 1'b0, 7, 9, 9);
        idle(9, 7, 9);

        // Flush overrides same-cycle issue.
        step(1'b0, 0, '0, 1'b1, 1, 1'b0, 1, 2, 4);
        step(1'b0, 0, '0, 1'b1, 2, 1'b0, 1, 2, 4);
        step(1'b0, 0, '0, 1'b1, 4, 1'b0, 1, 2, 4);
        idle(1, 2, 4);
        step(1'b1, 2, 32'h77, 1'b1, 6, 1'b1, 6, 2, 1);
        idle(6, 2, 4);

        // Issue every register: full-width pend_cnt on the plain-x0 instance.
        for (int r = 0; r < 32; r++) step(1'b0, 0, '0, 1'b1, r, 1'b0, r, 0, 31);
        idle(0, 31, 0);
        step(1'b1, 0, 32'hA, 1'b0, 0, 1'b0, 0, 0, 0);
        idle(0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), 1'($urandom_range(0, 1)),
                 rnd_addr(), ($urandom_range(0, 15) == 0), rnd_addr(), rnd_addr(), rnd_addr());
        end
        idle(1, 2, 3);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
